serial_subtractor: RTL

- Bit-serial N-bit subtractor: computes diff = a - b, LSB first, one bit per clock, using a single 1-bit full-subtractor cell and a registered borrow.
- Arithmetic counterpart to the team's combinational full-adder cells.
- Used where area matters more than latency.
- Operands enter and results leave through valid/ready handshakes.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor_cell.sv | 13 +
 rtl/serial_subtractor.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and reset state.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam state_e STATE_RST = IDLE;

endpackage

// File: rtl/full_subtractor_cell.sv
// 1-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) with valid/ready handshakes.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic             bout_q, bout_d;
  logic             cell_d, cell_bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  full_subtractor_cell u_cell (
    .x   (a_sr_q[0]),
    .y   (b_sr_q[0]),
    .bin (bor_q),
    .d   (cell_d),
    .bout(cell_bout)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    dsr_d   = dsr_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    bor_d   = bor_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          dsr_d   = '0;
          bor_d   = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        // Shift then overwrite the MSB so WIDTH=1 needs no zero-width slice.
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        dsr_d  = dsr_q >> 1;
        dsr_d[WIDTH-1] = cell_d;
        bor_d  = cell_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = dsr_d;
          bout_d  = cell_bout;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STATE_RST;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      dsr_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      bor_q   <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      dsr_q   <= dsr_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      bor_q   <= bor_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign start_ready = (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  assign busy        = (state_q == RUN);
  assign diff        = diff_q;
  assign borrow_out  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf         = ovf_q;
`endif

endmodule
